lcg_stim_gen: RTL and testbench

- Synthesizable, parametrised LCG stimulus source for the fuzz harness.
- Produces a wide, flat stimulus word per accepted transfer. The word bit-matches the testbench LCG sequence: state = state*32'h41C64E6D + 32'h3039 mod 2^32.
- Adds a valid/ready output handshake, start/stop/done control, a bounded-count mode and an accepted-word index.
- Sits between harness control and the DUT's in_flat, so stimulus can live in hardware (emulation/FPGA) instead of the testbench.

---
 rtl/lcg_stim_gen.sv | 120 ++++++++++++
 tb/tb_lcg_stim_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: LCG stimulus word source with valid/ready handshake and run control; trace log under LCG_STIM_TRACE_EN
module lcg_stim_gen #(
    parameter int          OUT_W = 337,
    parameter logic [31:0] SEED  = 32'd1735072617,
    parameter int          CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  logic [31:0]      seed_i,
    input  logic [CNT_W-1:0] count_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] word_idx_o
);
    localparam int          LANES = (OUT_W + 31) / 32;
    localparam logic [31:0] MUL   = 32'h41C6_4E6D;
    localparam logic [31:0] INC   = 32'h0000_3039;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             st, st_nxt;
    logic [31:0]        rng, rng_nxt, lane_s;
    logic               mode, mode_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, idx_nxt;
    logic [OUT_W-1:0]   data_nxt, gen_word;
    logic [LANES*32-1:0] lanes;
    logic               valid_nxt, accept, last;

    // Chain LANES LCG steps from the seed (idle) or running state; lane_s ends as the next rng state
    always_comb begin
        lane_s = (st == RUN) ? rng : seed_i;
        lanes = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_s = lane_s * MUL + INC;
            lanes[32*k +: 32] = lane_s;
        end
        gen_word = OUT_W'(lanes);
    end

    // Run control: start/stop/count decisions, handshake holding and word-index bookkeeping
    always_comb begin
        st_nxt = st;
        rng_nxt = rng;
        mode_nxt = mode;
        cnt_nxt = cnt;
        data_nxt = out_data_o;
        valid_nxt = out_valid_o;
        idx_nxt = word_idx_o;
        accept = out_valid_o && out_ready_i;
        last = accept && mode && (word_idx_o + CNT_W'(1) == cnt);
        case (st)
            IDLE: begin
                if (start_i) begin
                    mode_nxt = mode_i;
                    cnt_nxt = count_i;
                    idx_nxt = '0;
                    if (mode_i && count_i == '0) begin
                        st_nxt = DONE;
                        rng_nxt = seed_i;
                    end else begin
                        st_nxt = RUN;
                        data_nxt = gen_word;
                        valid_nxt = 1'b1;
                        rng_nxt = lane_s;
                    end
                end
            end
            RUN: begin
                if (accept) idx_nxt = word_idx_o + CNT_W'(1);
                if (last || stop_i) begin
                    st_nxt = DONE;
                    valid_nxt = 1'b0;
                end else if (accept) begin
                    data_nxt = gen_word;
                    rng_nxt = lane_s;
                end
            end
            DONE: st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // State and output registers; reset overrides every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            rng <= SEED;
            mode <= 1'b0;
            cnt <= '0;
            out_data_o <= '0;
            out_valid_o <= 1'b0;
            word_idx_o <= '0;
        end else begin
            st <= st_nxt;
            rng <= rng_nxt;
            mode <= mode_nxt;
            cnt <= cnt_nxt;
            out_data_o <= data_nxt;
            out_valid_o <= valid_nxt;
            word_idx_o <= idx_nxt;
        end
    end

    assign busy_o = (st == RUN);
    assign done_o = (st == DONE);

`ifdef LCG_STIM_TRACE_EN
    // Simulation-only log of accepted words and run completion in the harness format
    always_ff @(posedge clk) begin
        if (!rst && out_valid_o && out_ready_i) $write("CYCLE=%0d IN=%h\n", word_idx_o, out_data_o);
        if (!rst && done_o) $write("STIM_DONE words=%0d\n", word_idx_o);
    end
`endif
endmodule

// File: tb/tb_lcg_stim_gen.sv
// tb_lcg_stim_gen: three widths (337/64/40) in lockstep against an LCG scoreboard model
module tb_lcg_stim_gen;
    localparam int          NW = 352;
    localparam logic [31:0] A  = 32'h41C6_4E6D;
    localparam logic [31:0] C  = 32'h0000_3039;
    localparam logic [31:0] S0 = 32'd1735072617;

    logic        clk = 0, rst = 1, start_i = 0, stop_i = 0, mode_i = 0, out_ready_i = 0;
    logic [31:0] seed_i = 0, count_i = 0;
    logic [336:0] data0;
    logic [63:0]  data1;
    logic [39:0]  data2;
    logic [2:0]   vld, bsy, dn;
    logic [31:0]  idx [3];

    int checks = 0, errors = 0;
    logic [NW-1:0] sq [3][$];
    logic [31:0]   ms [3];
    int LN [3] = '{11, 2, 2};
    int WD [3] = '{337, 64, 40};

    always #5 clk = ~clk;

    lcg_stim_gen #(.OUT_W(337)) d0 (.clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .mode_i(mode_i),
        .seed_i(seed_i), .count_i(count_i), .out_data_o(data0), .out_valid_o(vld[0]), .out_ready_i(out_ready_i),
        .busy_o(bsy[0]), .done_o(dn[0]), .word_idx_o(idx[0]));
    lcg_stim_gen #(.OUT_W(64)) d1 (.clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .mode_i(mode_i),
        .seed_i(seed_i), .count_i(count_i), .out_data_o(data1), .out_valid_o(vld[1]), .out_ready_i(out_ready_i),
        .busy_o(bsy[1]), .done_o(dn[1]), .word_idx_o(idx[1]));
    lcg_stim_gen #(.OUT_W(40)) d2 (.clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .mode_i(mode_i),
        .seed_i(seed_i), .count_i(count_i), .out_data_o(data2), .out_valid_o(vld[2]), .out_ready_i(out_ready_i),
        .busy_o(bsy[2]), .done_o(dn[2]), .word_idx_o(idx[2]));

    function automatic logic [NW-1:0] lcg_word(input logic [31:0] s, input int lanes, input int w,
                                               output logic [31:0] ns);
        logic [NW-1:0] r;
        logic [31:0] x;
        r = '0;
        x = s;
        for (int k = 0; k < lanes; k++) begin
            x = x * A + C;
            r[32*k +: 32] = x;
        end
        for (int b = w; b < NW; b++) r[b] = 1'b0;
        ns = x;
        return r;
    endfunction

    function automatic logic [NW-1:0] dut_word(input int i);
        return (i == 0) ? NW'(data0) : (i == 1) ? NW'(data1) : NW'(data2);
    endfunction

    task automatic chk(input string nm, input logic [NW-1:0] a, input logic [NW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, a, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic [31:0] sd, input logic [31:0] n);
        logic [31:0] t;
        mode_i = m;
        seed_i = sd;
        count_i = n;
        start_i = 1;
        for (int i = 0; i < 3; i++) begin
            sq[i].delete();
            sq[i].push_back(lcg_word(sd, LN[i], WD[i], t));
            ms[i] = t;
        end
        tick;
        start_i = 0;
    endtask

    // Scoreboard: every accepted word is popped and compared, then the model's next word is queued
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (vld[i] && out_ready_i) begin
                    if (sq[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty dut=%0d", i);
                    end else begin
                        chk($sformatf("word_w%0d", WD[i]), dut_word(i), sq[i].pop_front());
                        sq[i].push_back(lcg_word(ms[i], LN[i], WD[i], ms[i]));
                    end
                end
            end
        end
    end

    typedef struct {
        logic [31:0] seed;
        logic [31:0] count;
        int          n;
        logic        has_first;
        logic [63:0] first64;
        logic [39:0] first40;
    } vec_t;

    vec_t tv [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int nv, nd, done_at;
        logic [NW-1:0] hold, exp_first;
        logic [31:0] t;
        tv[0] = '{32'd0, 32'd2, 2, 1'b1, 64'hD3DC167E_00003039, 40'h7E_00003039};
        tv[1] = '{32'd0, 32'd1, 1, 1'b1, 64'hD3DC167E_00003039, 40'h7E_00003039};
        tv[2] = '{S0, 32'd5, 5, 1'b0, 64'h0, 40'h0};
        tv[3] = '{32'hFFFF_FFFF, 32'd3, 3, 1'b0, 64'h0, 40'h0};
        tv[4] = '{32'h1234_5678, 32'd0, 0, 1'b0, 64'h0, 40'h0};

        repeat (3) tick;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", vld[i], 0);
            chk("rst_busy", bsy[i], 0);
            chk("rst_done", dn[i], 0);
            chk("rst_idx", idx[i], 0);
        end
        chk("rst_data", data0, 0);
        tick;
        rst = 0;
        stop_i = 1;
        tick;
        stop_i = 0;
        @(negedge clk);
        chk("idle_stop_busy", bsy[0], 0);
        chk("idle_stop_done", dn[0], 0);

        // Count-mode table: valid cycles, done timing and final index per vector
        for (int v = 0; v < 5; v++) begin
            tick;
            out_ready_i = 1;
            do_start(1, tv[v].seed, tv[v].count);
            nv = 0;
            nd = 0;
            done_at = -1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (c == 0 && tv[v].has_first) begin
                    chk("first64", data1, tv[v].first64);
                    chk("first40", data2, tv[v].first40);
                end
                if (vld[0]) nv++;
                if (dn[0]) begin
                    nd++;
                    if (done_at < 0) done_at = c;
                end
                if (done_at >= 0 && c >= done_at + 2) break;
            end
            chk($sformatf("v%0d_valid_cycles", v), NW'(nv), NW'(tv[v].n));
            chk($sformatf("v%0d_done_at", v), NW'(done_at), NW'(tv[v].n));
            chk($sformatf("v%0d_done_pulses", v), NW'(nd), 1);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("v%0d_idx_w%0d", v, WD[i]), idx[i], tv[v].n);
                chk($sformatf("v%0d_busy_w%0d", v, WD[i]), bsy[i], 0);
            end
        end

        // Backpressure: word and index hold while ready is low
        tick;
        out_ready_i = 0;
        do_start(0, 32'hCAFE_F00D, 0);
        @(negedge clk);
        hold = NW'(data0);
        chk("bp_first", hold, sq[0][0]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", vld[0], 1);
            chk("bp_hold", data0, hold);
            chk("bp_idx", idx[0], 0);
        end
        tick;
        out_ready_i = 1;
        repeat (4) tick;
        out_ready_i = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("bp_idx4", idx[i], 4);
        tick;
        stop_i = 1;
        tick;
        stop_i = 0;
        @(negedge clk);
        chk("bp_stop_done", dn[0], 1);
        chk("bp_stop_valid", vld[0], 0);
        chk("bp_stop_idx", idx[0], 4);

        // Free-run from S0: a start pulse mid-run is ignored, stop lands on the 31st accept
        tick;
        out_ready_i = 1;
        do_start(0, S0, 0);
        repeat (10) tick;
        start_i = 1;
        seed_i = 32'h0BAD_BEEF;
        mode_i = 1;
        count_i = 1;
        tick;
        start_i = 0;
        repeat (19) tick;
        stop_i = 1;
        tick;
        stop_i = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("fr_done", dn[i], 1);
            chk("fr_valid", vld[i], 0);
            chk("fr_idx31", idx[i], 31);
        end
        hold = NW'(data0);
        repeat (2) @(negedge clk);
        chk("fr_data_stable", data0, hold);
        chk("fr_done_once", dn[0], 0);
        chk("fr_busy", bsy[0], 0);

        // Reset mid-run at word 3, then the same seed reproduces the first word
        tick;
        out_ready_i = 1;
        do_start(0, 32'h00C0_FFEE, 0);
        repeat (3) tick;
        @(negedge clk);
        chk("mr_idx3", idx[0], 3);
        rst = 1;
        tick;
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("mr_valid", vld[i], 0);
            chk("mr_busy", bsy[i], 0);
            chk("mr_idx", idx[i], 0);
        end
        out_ready_i = 0;
        do_start(0, 32'h00C0_FFEE, 0);
        @(negedge clk);
        exp_first = lcg_word(32'h00C0_FFEE, 11, 337, t);
        chk("mr_rerun_first", data0, exp_first);
        chk("mr_rerun_valid", vld[0], 1);

        // Count mode with the largest count runs until stopped
        tick;
        stop_i = 1;
        tick;
        stop_i = 0;
        tick;
        out_ready_i = 1;
        do_start(1, 32'd1, 32'hFFFF_FFFF);
        repeat (3) tick;
        stop_i = 1;
        tick;
        stop_i = 0;
        @(negedge clk);
        chk("max_cnt_done", dn[0], 1);
        chk("max_cnt_idx", idx[0], 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
